// File: rtl/vending_machine_param.sv
// vending_machine_param: coin vending controller with programmable price.
// Accumulates nickel/dime/quarter credit, raises Vend until VendAck, then
// pays change (or a cancel refund) one coin per cycle, largest coin first.
// Optional feature macro VM_SALES_COUNT_EN adds a saturating 16-bit
// SalesCount output counting acknowledged vends.
//
// Handshake: Vend is a level request that stays high from the cycle after
// the purchasing coin until the cycle after VendAck is sampled high while
// in VEND; VendAck outside VEND has no effect. Coin inputs are one-cycle
// pulses; CoinReject answers every coin that is not credited.
module vending_machine_param #(
    parameter int PRICE      = 30,
    parameter int MAX_CREDIT = 50,
    parameter int CW         = 7
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          N,
    input  logic          D,
    input  logic          Q,
    input  logic          Cancel,
    input  logic          VendAck,
    output logic [CW-1:0] Credit,
    output logic          Vend,
    output logic          RetN,
    output logic          RetD,
    output logic          RetQ,
    output logic          CoinReject,
    output logic          Busy
`ifdef VM_SALES_COUNT_EN
    ,
    output logic [15:0]   SalesCount
`endif
);

    // Reject illegal parameter sets while elaborating.
    if ((PRICE % 5) != 0 || (MAX_CREDIT % 5) != 0 || PRICE < 5 ||
        PRICE > MAX_CREDIT || MAX_CREDIT >= (1 << CW)) begin : g_param_check
        $error("vending_machine_param: illegal PRICE/MAX_CREDIT/CW combination");
    end

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW:0] MAX_W   = (CW+1)'(MAX_CREDIT);

    state_e        state_q;
    logic [CW-1:0] credit_q;
    logic          vend_q, retn_q, retd_q, retq_q, reject_q, busy_q;

    logic          coin_any;
    logic          coin_legal;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;       // one extra bit so the overflow test never wraps
    logic          coin_ok;
    logic [CW-1:0] ret_val;

    assign coin_any   = N | D | Q;
    assign coin_legal = (N & ~D & ~Q) | (~N & D & ~Q) | (~N & ~D & Q);
    assign sum        = {1'b0, credit_q} + coin_val;
    assign coin_ok    = coin_legal && (sum <= MAX_W);

    // Value of the single legal coin; don't-care when the coin is illegal.
    always_comb begin
        coin_val = '0;
        if (N)      coin_val = (CW+1)'(5);
        else if (D) coin_val = (CW+1)'(10);
        else if (Q) coin_val = (CW+1)'(25);
    end

    // Greedy change coin for the credit still owed.
    always_comb begin
        ret_val = CW'(5);
        if (32'(credit_q) >= 32'd25)      ret_val = CW'(25);
        else if (32'(credit_q) >= 32'd10) ret_val = CW'(10);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_ACCUM;
            credit_q <= '0;
            vend_q   <= 1'b0;
            retn_q   <= 1'b0;
            retd_q   <= 1'b0;
            retq_q   <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            retn_q   <= 1'b0;
            retd_q   <= 1'b0;
            retq_q   <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                ST_ACCUM: begin
                    if (Cancel) begin
                        // Cancel wins over a simultaneous coin.
                        reject_q <= coin_any;
                        if (credit_q != '0) begin
                            state_q <= ST_CHANGE;
                            busy_q  <= 1'b1;
                        end
                    end else if (coin_any) begin
                        if (!coin_ok) begin
                            reject_q <= 1'b1;
                        end else if (sum < PRICE_W) begin
                            credit_q <= CW'(sum);
                        end else begin
                            credit_q <= CW'(sum - PRICE_W);
                            state_q  <= ST_VEND;
                            vend_q   <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                ST_VEND: begin
                    reject_q <= coin_any;
                    if (VendAck) begin
                        vend_q <= 1'b0;
                        if (credit_q != '0) begin
                            state_q <= ST_CHANGE;
                        end else begin
                            state_q <= ST_ACCUM;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_CHANGE: begin
                    reject_q <= coin_any;
                    retq_q   <= (ret_val == CW'(25));
                    retd_q   <= (ret_val == CW'(10));
                    retn_q   <= (ret_val == CW'(5));
                    credit_q <= credit_q - ret_val;
                    if (credit_q == ret_val) begin
                        state_q <= ST_ACCUM;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                    busy_q  <= 1'b0;
                    vend_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VM_SALES_COUNT_EN
    logic [15:0] sales_q;

    // Count acknowledged vends, saturating at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sales_q <= '0;
        end else if (state_q == ST_VEND && VendAck && sales_q != 16'hFFFF) begin
            sales_q <= sales_q + 16'd1;
        end
    end

    assign SalesCount = sales_q;
`endif

    assign Credit     = credit_q;
    assign Vend       = vend_q;
    assign RetN       = retn_q;
    assign RetD       = retd_q;
    assign RetQ       = retq_q;
    assign CoinReject = reject_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: two instances (MAX_CREDIT 50 and 40,
// PRICE 30) share stimulus; a per-instance behavioural model is stepped
// each clock and all outputs are compared #1 after the rising edge.
`timescale 1ns/1ps
module tb_vending_machine_param;
  localparam int CW = 7;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic N = 1'b0, D = 1'b0, Q = 1'b0, Cancel = 1'b0, VendAck = 1'b0;

  logic [CW-1:0] credit_o [2];
  logic          vend_o   [2];
  logic          retn_o   [2];
  logic          retd_o   [2];
  logic          retq_o   [2];
  logic          rej_o    [2];
  logic          busy_o   [2];
`ifdef VM_SALES_COUNT_EN
  logic [15:0]   sales_o  [2];
`endif

  // clock / reset block
  always #5 Clk = ~Clk;

  vending_machine_param #(.PRICE(30), .MAX_CREDIT(50), .CW(CW)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .N(N), .D(D), .Q(Q), .Cancel(Cancel), .VendAck(VendAck),
    .Credit(credit_o[0]), .Vend(vend_o[0]), .RetN(retn_o[0]), .RetD(retd_o[0]),
    .RetQ(retq_o[0]), .CoinReject(rej_o[0]), .Busy(busy_o[0])
`ifdef VM_SALES_COUNT_EN
    , .SalesCount(sales_o[0])
`endif
  );

  vending_machine_param #(.PRICE(30), .MAX_CREDIT(40), .CW(CW)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .N(N), .D(D), .Q(Q), .Cancel(Cancel), .VendAck(VendAck),
    .Credit(credit_o[1]), .Vend(vend_o[1]), .RetN(retn_o[1]), .RetD(retd_o[1]),
    .RetQ(retq_o[1]), .CoinReject(rej_o[1]), .Busy(busy_o[1])
`ifdef VM_SALES_COUNT_EN
    , .SalesCount(sales_o[1])
`endif
  );

  int total = 0;
  int bad = 0;

  // reference model: phase 0 = collecting coins, 1 = waiting for ack, 2 = paying out
  int p_price [2] = '{30, 30};
  int p_max   [2] = '{50, 40};
  int m_phase [2];
  int m_owed  [2];
  int m_rej   [2];
  int m_rn    [2];
  int m_rd    [2];
  int m_rq    [2];
  int m_sales [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_owed[i] = 0; m_rej[i] = 0;
      m_rn[i] = 0; m_rd[i] = 0; m_rq[i] = 0; m_sales[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit n, input bit d, input bit q,
                            input bit c, input bit a);
    int coins;
    int val;
    int pay;
    coins = int'(n) + int'(d) + int'(q);
    val = n ? 5 : (d ? 10 : 25);
    m_rej[i] = 0; m_rn[i] = 0; m_rd[i] = 0; m_rq[i] = 0;
    case (m_phase[i])
      0: begin
        if (c) begin
          m_rej[i] = (coins > 0) ? 1 : 0;
          if (m_owed[i] > 0) m_phase[i] = 2;
        end else if (coins > 0) begin
          if (coins == 1 && m_owed[i] + val <= p_max[i]) begin
            if (m_owed[i] + val >= p_price[i]) begin
              m_owed[i] = m_owed[i] + val - p_price[i];
              m_phase[i] = 1;
            end else begin
              m_owed[i] = m_owed[i] + val;
            end
          end else begin
            m_rej[i] = 1;
          end
        end
      end
      1: begin
        m_rej[i] = (coins > 0) ? 1 : 0;
        if (a) begin
          if (m_sales[i] < 65535) m_sales[i]++;
          m_phase[i] = (m_owed[i] > 0) ? 2 : 0;
        end
      end
      default: begin
        m_rej[i] = (coins > 0) ? 1 : 0;
        pay = (m_owed[i] >= 25) ? 25 : ((m_owed[i] >= 10) ? 10 : 5);
        m_rq[i] = (pay == 25) ? 1 : 0;
        m_rd[i] = (pay == 10) ? 1 : 0;
        m_rn[i] = (pay == 5) ? 1 : 0;
        m_owed[i] = m_owed[i] - pay;
        if (m_owed[i] == 0) m_phase[i] = 0;
      end
    endcase
  endtask

  // scoreboard: every output of both instances against the model
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("credit%0d", i), 32'(credit_o[i]), m_owed[i]);
      chk($sformatf("vend%0d", i), 32'(vend_o[i]), (m_phase[i] == 1) ? 1 : 0);
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), (m_phase[i] != 0) ? 1 : 0);
      chk($sformatf("reject%0d", i), 32'(rej_o[i]), m_rej[i]);
      chk($sformatf("retn%0d", i), 32'(retn_o[i]), m_rn[i]);
      chk($sformatf("retd%0d", i), 32'(retd_o[i]), m_rd[i]);
      chk($sformatf("retq%0d", i), 32'(retq_o[i]), m_rq[i]);
`ifdef VM_SALES_COUNT_EN
      chk($sformatf("sales%0d", i), 32'(sales_o[i]), m_sales[i]);
`endif
    end
  endtask

  // driver tasks
  task automatic cycle(input bit n, input bit d, input bit q, input bit c, input bit a);
    N = n; D = d; Q = q; Cancel = c; VendAck = a;
    @(posedge Clk);
    for (int i = 0; i < 2; i++) model_step(i, n, d, q, c, a);
    #1;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    N = 0; D = 0; Q = 0; Cancel = 0; VendAck = 0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    int r;
    bit rn, rd, rq, rc, ra;

    // reset state
    #2;
    do_reset();

    // exact price: Q then N, vend held 5 cycles, no change
    cycle(0, 0, 1, 0, 0);
    chk("tp1_credit25", 32'(credit_o[0]), 25);
    cycle(1, 0, 0, 0, 0);
    chk("tp1_credit0", 32'(credit_o[0]), 0);
    chk("tp1_vend", 32'(vend_o[0]), 1);
    idle(4);
    cycle(0, 0, 0, 0, 1);
    chk("tp1_busy_after_ack", 32'(busy_o[0]), 0);
    idle(1);

    // Q, Q: 20 owed, two dimes after ack
    do_reset();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("tp2_credit20", 32'(credit_o[0]), 20);
    chk("tp2_inst1_reject", 32'(rej_o[1]), 1);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    chk("tp2_retd_a", 32'(retd_o[0]), 1);
    idle(1);
    chk("tp2_retd_b", 32'(retd_o[0]), 1);
    chk("tp2_done", 32'(busy_o[0]), 0);
    idle(1);

    // N, D, Cancel: refund dime then nickel; second cancel ignored
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("tp3_credit15", 32'(credit_o[0]), 15);
    cycle(0, 0, 0, 1, 0);
    idle(2);
    cycle(0, 0, 0, 1, 0);
    chk("tp3_no_pulse", 32'(retn_o[0]), 0);
    idle(1);

    // multi-hot coin, coin during VEND, cancel with coin
    do_reset();
    cycle(1, 1, 0, 0, 0);
    chk("tp4_multihot_rej", 32'(rej_o[0]), 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("tp4_vend_coin_rej", 32'(rej_o[0]), 1);
    chk("tp4_vend_credit", 32'(credit_o[0]), 20);
    cycle(0, 0, 0, 0, 1);
    idle(3);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    chk("tp4_cancel_coin_rej", 32'(rej_o[0]), 1);
    idle(2);

    // overflow boundary on the MAX_CREDIT=40 instance
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("tp5_over_rej", 32'(rej_o[1]), 1);
    chk("tp5_credit20", 32'(credit_o[1]), 20);
    cycle(0, 1, 0, 0, 0);
    chk("tp5_vend", 32'(vend_o[1]), 1);
    chk("tp5_credit0", 32'(credit_o[1]), 0);
    cycle(0, 0, 0, 0, 1);
    idle(3);

    // reset between change pulses
    do_reset();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    chk("tp6_first_pulse", 32'(retd_o[0]), 1);
    #1;
    do_reset();
    chk("tp6_credit_cleared", 32'(credit_o[0]), 0);
    idle(2);
    cycle(1, 0, 0, 0, 0);
    chk("tp6_credit5", 32'(credit_o[0]), 5);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      r  = $urandom_range(0, 9);
      rn = (r == 0 || r == 3 || r == 4);
      rd = (r == 1 || r == 3);
      rq = (r == 2 || r == 4);
      rc = ($urandom_range(0, 11) == 0);
      ra = ($urandom_range(0, 2) == 0);
      cycle(rn, rd, rq, rc, ra);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
